// File: rtl/asteroids_pkg.sv
// Shared types and ROM map for the Asteroids download path.
// Region sizes default to the original board's ROM layout.
package asteroids_pkg;

    localparam int unsigned PROG_SIZE_DEF = 6144;
    localparam int unsigned VEC_SIZE_DEF  = 2048;
    localparam int unsigned PROM_SIZE_DEF = 256;
    localparam int unsigned HOLD_DEF      = 1024;

    localparam int unsigned PROG_BASE = 0;
    localparam int unsigned VEC_BASE  = PROG_BASE + PROG_SIZE_DEF;
    localparam int unsigned PROM_BASE = VEC_BASE + VEC_SIZE_DEF;
    localparam int unsigned TOTAL_DEF = PROM_BASE + PROM_SIZE_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_FAIL
    } dl_state_t;

    typedef enum logic [1:0] {
        REG_PROG,
        REG_VEC,
        REG_PROM,
        REG_NONE
    } region_t;

endpackage

// File: rtl/rom_dl_ctrl_if.sv
// HPS download channel bundle (ioctl_download/wr/addr/dout).
// master is the hps_io side, slave is the ROM download controller.
interface rom_dl_ctrl_if;

    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;

    modport master (
        output dl_active,
        output dl_wr,
        output dl_addr,
        output dl_data
    );

    modport slave (
        input dl_active,
        input dl_wr,
        input dl_addr,
        input dl_data
    );

endinterface

// File: rtl/dl_region_decode.sv
// Combinational split of a flat download offset into ROM region
// and region-relative address.
module dl_region_decode
    import asteroids_pkg::*;
#(
    parameter int unsigned PROG_SIZE = PROG_SIZE_DEF,
    parameter int unsigned VEC_SIZE  = VEC_SIZE_DEF,
    parameter int unsigned PROM_SIZE = PROM_SIZE_DEF
) (
    input  logic [15:0] addr_i,
    output region_t     region_o,
    output logic [12:0] rel_o
);

    localparam logic [15:0] V_BASE = 16'(PROG_SIZE);
    localparam logic [15:0] P_BASE = 16'(PROG_SIZE + VEC_SIZE);
    localparam logic [15:0] END_A  = 16'(PROG_SIZE + VEC_SIZE + PROM_SIZE);

    // Region offsets stay below 8 KiB, so 13-bit arithmetic is exact.
    always_comb begin
        region_o = REG_NONE;
        rel_o    = '0;
        unique case (1'b1)
            (addr_i < V_BASE): begin
                region_o = REG_PROG;
                rel_o    = addr_i[12:0];
            end
            (addr_i >= V_BASE && addr_i < P_BASE): begin
                region_o = REG_VEC;
                rel_o    = addr_i[12:0] - V_BASE[12:0];
            end
            (addr_i >= P_BASE && addr_i < END_A): begin
                region_o = REG_PROM;
                rel_o    = addr_i[12:0] - P_BASE[12:0];
            end
            default: begin
                region_o = REG_NONE;
                rel_o    = '0;
            end
        endcase
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download controller: routes the HPS byte stream into the three
// Asteroids ROMs and holds the core in reset until a verified load settles.
module rom_dl_ctrl
    import asteroids_pkg::*;
#(
    parameter int unsigned PROG_SIZE   = PROG_SIZE_DEF,
    parameter int unsigned VEC_SIZE    = VEC_SIZE_DEF,
    parameter int unsigned PROM_SIZE   = PROM_SIZE_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_DEF
) (
    input  logic               clk_25,
    input  logic               reset,
    rom_dl_ctrl_if.slave       dl,
    output logic               prog_we,
    output logic               vec_we,
    output logic               prom_we,
    output logic [12:0]        wr_addr,
    output logic [7:0]         wr_data,
    output logic               core_reset,
    output logic               load_ok,
    output logic               load_err,
    output logic [15:0]        byte_count
);

    localparam logic [15:0] TOTAL     = 16'(PROG_SIZE + VEC_SIZE + PROM_SIZE);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    dl_state_t   state_q;
    logic        prog_we_q;
    logic        vec_we_q;
    logic        prom_we_q;
    logic [12:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        core_reset_q;
    logic        load_ok_q;
    logic        load_err_q;
    logic [15:0] byte_cnt_q;
    logic [15:0] hold_q;
    logic        err_q;
    logic        first_q;
    logic [15:0] last_q;

    region_t     region;
    logic [12:0] rel;
    logic [15:0] byte_cnt_d;
    logic        seq_bad;
    logic        start;

    dl_region_decode #(
        .PROG_SIZE (PROG_SIZE),
        .VEC_SIZE  (VEC_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_dec (
        .addr_i   (dl.dl_addr),
        .region_o (region),
        .rel_o    (rel)
    );

    assign byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q
                                                 : byte_cnt_q + 16'd1;
    assign seq_bad    = !first_q && (dl.dl_addr != last_q + 16'd1);
    assign start      = dl.dl_active && (state_q inside
                        {S_IDLE, S_HOLD, S_RUN, S_FAIL});

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prog_we_q    <= 1'b0;
            vec_we_q     <= 1'b0;
            prom_we_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
            byte_cnt_q   <= '0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            first_q      <= 1'b1;
            last_q       <= '0;
        end else begin
            prog_we_q <= 1'b0;
            vec_we_q  <= 1'b0;
            prom_we_q <= 1'b0;
            if (start) begin
                state_q      <= S_LOAD;
                core_reset_q <= 1'b1;
                load_ok_q    <= 1'b0;
                load_err_q   <= 1'b0;
                byte_cnt_q   <= '0;
                err_q        <= 1'b0;
                first_q      <= 1'b1;
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        // A write coincident with the dl_active fall still lands.
                        if (dl.dl_wr) begin
                            if (region != REG_NONE) begin
                                prog_we_q  <= (region == REG_PROG);
                                vec_we_q   <= (region == REG_VEC);
                                prom_we_q  <= (region == REG_PROM);
                                wr_addr_q  <= rel;
                                wr_data_q  <= dl.dl_data;
                                byte_cnt_q <= byte_cnt_d;
                                last_q     <= dl.dl_addr;
                                first_q    <= 1'b0;
                                if (seq_bad) err_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        if (!dl.dl_active) state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (byte_cnt_q == TOTAL && !err_q) begin
                            state_q <= S_HOLD;
                            hold_q  <= '0;
                        end else begin
                            state_q    <= S_FAIL;
                            load_err_q <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q      <= S_RUN;
                            core_reset_q <= 1'b0;
                            load_ok_q    <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 16'd1;
                        end
                    end
                    S_IDLE, S_RUN, S_FAIL: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        core_reset_q <= 1'b1;
                        load_ok_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign prog_we    = prog_we_q;
    assign vec_we     = vec_we_q;
    assign prom_we    = prom_we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_reset = core_reset_q;
    assign load_ok    = load_ok_q;
    assign load_err   = load_err_q;
    assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl: full, short, bad-address, reset-abort
// and re-download scenarios with default ROM sizes and 1024-cycle hold.
module tb_rom_dl_ctrl;

    logic        clk_25;
    logic        reset;
    logic        prog_we;
    logic        vec_we;
    logic        prom_we;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        core_reset;
    logic        load_ok;
    logic        load_err;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;
    int n_prog = 0;
    int n_vec  = 0;
    int n_prom = 0;

    int          bnd_a [5] = '{6143, 6144, 8191, 8192, 8447};
    int          bnd_r [5] = '{6143, 0, 2047, 0, 255};
    logic [2:0]  bnd_w [5] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001};

    rom_dl_ctrl_if dl_bus ();

    rom_dl_ctrl dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .dl         (dl_bus.slave),
        .prog_we    (prog_we),
        .vec_we     (vec_we),
        .prom_we    (prom_we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .load_ok    (load_ok),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    initial clk_25 = 1'b0;
    always #5 clk_25 = ~clk_25;

    always @(negedge clk_25) begin
        if (prog_we) n_prog++;
        if (vec_we)  n_vec++;
        if (prom_we) n_prom++;
    end

    task automatic step;
        @(posedge clk_25);
        #1;
    endtask

    function automatic logic [7:0] dbyte(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic feed(input int nbytes, input int inject_at,
                        input bit coinc);
        for (int i = 0; i < nbytes; i++) begin
            if (i == inject_at) begin
                dl_bus.dl_wr   = 1'b1;
                dl_bus.dl_addr = 16'd9000;
                dl_bus.dl_data = 8'hEE;
                step();
            end
            dl_bus.dl_wr   = 1'b1;
            dl_bus.dl_addr = 16'(i);
            dl_bus.dl_data = dbyte(i);
            if (coinc && i == nbytes - 1) dl_bus.dl_active = 1'b0;
            step();
        end
        dl_bus.dl_wr = 1'b0;
        if (!coinc) begin
            dl_bus.dl_active = 1'b0;
            step();
        end
    endtask

    task automatic wait_release(output int n);
        n = 1;
        while (core_reset === 1'b1 && n < 3000) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        checks++;
        if ({core_reset, load_ok, load_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got %b exp 100",
                     {core_reset, load_ok, load_err});
        end
        checks++;
        if ({prog_we, vec_we, prom_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_we got %b exp 000",
                     {prog_we, vec_we, prom_we});
        end
        checks++;
        if (wr_addr !== 13'd0 || wr_data !== 8'd0 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs got %0d %0d %0d exp 0 0 0",
                     wr_addr, wr_data, byte_count);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_core_reset got %b exp 1", core_reset);
        end
    endtask

    task automatic test_full_load;
        int n;
        int p0, v0, r0;
        p0 = n_prog;
        v0 = n_vec;
        r0 = n_prom;
        dl_bus.dl_active = 1'b1;
        step();
        for (int i = 0; i < 8448; i++) begin
            dl_bus.dl_wr   = 1'b1;
            dl_bus.dl_addr = 16'(i);
            dl_bus.dl_data = dbyte(i);
            step();
            for (int b = 0; b < 5; b++) begin
                if (i == bnd_a[b]) begin
                    checks++;
                    if ({prog_we, vec_we, prom_we} !== bnd_w[b] ||
                        wr_addr !== 13'(bnd_r[b]) || wr_data !== dbyte(i)) begin
                        errors++;
                        $display("FAIL boundary_%0d got we=%b a=%0d d=%0h exp we=%b a=%0d d=%0h",
                                 i, {prog_we, vec_we, prom_we}, wr_addr, wr_data,
                                 bnd_w[b], bnd_r[b], dbyte(i));
                    end
                end
            end
        end
        dl_bus.dl_wr     = 1'b0;
        dl_bus.dl_active = 1'b0;
        step();
        checks++;
        if (wr_addr !== 13'd255 || wr_data !== dbyte(8447) ||
            {prog_we, vec_we, prom_we} !== 3'b000) begin
            errors++;
            $display("FAIL hold_wr got a=%0d d=%0h we=%b exp a=255 d=%0h we=000",
                     wr_addr, wr_data, {prog_we, vec_we, prom_we}, dbyte(8447));
        end
        wait_release(n);
        checks++;
        if (n != 1026) begin
            errors++;
            $display("FAIL full_release got %0d exp 1026", n);
        end
        checks++;
        if ({load_ok, load_err} !== 2'b10 || byte_count !== 16'd8448) begin
            errors++;
            $display("FAIL full_status got ok=%b err=%b cnt=%0d exp 1 0 8448",
                     load_ok, load_err, byte_count);
        end
        checks++;
        if (n_prog - p0 != 6144 || n_vec - v0 != 2048 || n_prom - r0 != 256) begin
            errors++;
            $display("FAIL full_strobes got %0d %0d %0d exp 6144 2048 256",
                     n_prog - p0, n_vec - v0, n_prom - r0);
        end
    endtask

    task automatic test_rerun;
        int n;
        dl_bus.dl_active = 1'b1;
        step();
        checks++;
        if ({core_reset, load_ok} !== 2'b10) begin
            errors++;
            $display("FAIL rerun_rise got rst=%b ok=%b exp 1 0",
                     core_reset, load_ok);
        end
        feed(8448, -1, 1'b1);
        checks++;
        if (byte_count !== 16'd8448) begin
            errors++;
            $display("FAIL rerun_count got %0d exp 8448", byte_count);
        end
        wait_release(n);
        checks++;
        if (n != 1026 || load_ok !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL rerun_release got n=%0d ok=%b err=%b exp 1026 1 0",
                     n, load_ok, load_err);
        end
    endtask

    task automatic test_short;
        dl_bus.dl_active = 1'b1;
        step();
        feed(8000, -1, 1'b0);
        step();
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL short_err got %b exp 1", load_err);
        end
        repeat (2000) step();
        checks++;
        if ({core_reset, load_ok, load_err} !== 3'b101 ||
            byte_count !== 16'd8000) begin
            errors++;
            $display("FAIL short_status got %b cnt=%0d exp 101 8000",
                     {core_reset, load_ok, load_err}, byte_count);
        end
    endtask

    task automatic test_bad_addr;
        int tot0;
        dl_bus.dl_active = 1'b1;
        step();
        checks++;
        if (load_err !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL bad_entry got err=%b rst=%b exp 0 1",
                     load_err, core_reset);
        end
        tot0 = n_prog + n_vec + n_prom;
        feed(8448, 4000, 1'b0);
        step();
        checks++;
        if (n_prog + n_vec + n_prom - tot0 != 8448) begin
            errors++;
            $display("FAIL bad_strobes got %0d exp 8448",
                     n_prog + n_vec + n_prom - tot0);
        end
        repeat (50) step();
        checks++;
        if (byte_count !== 16'd8448 || load_err !== 1'b1 ||
            core_reset !== 1'b1 || load_ok !== 1'b0) begin
            errors++;
            $display("FAIL bad_status got cnt=%0d err=%b rst=%b ok=%b exp 8448 1 1 0",
                     byte_count, load_err, core_reset, load_ok);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        dl_bus.dl_active = 1'b1;
        step();
        for (int i = 0; i < 3000; i++) begin
            dl_bus.dl_wr   = 1'b1;
            dl_bus.dl_addr = 16'(i);
            dl_bus.dl_data = dbyte(i);
            step();
        end
        dl_bus.dl_wr     = 1'b0;
        dl_bus.dl_active = 1'b0;
        reset            = 1'b1;
        step();
        checks++;
        if ({core_reset, load_ok, load_err, prog_we, vec_we, prom_we} !== 6'b100000 ||
            wr_addr !== 13'd0 || wr_data !== 8'd0 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got %b a=%0d d=%0h cnt=%0d exp 100000 0 0 0",
                     {core_reset, load_ok, load_err, prog_we, vec_we, prom_we},
                     wr_addr, wr_data, byte_count);
        end
        reset = 1'b0;
        step();
        dl_bus.dl_active = 1'b1;
        step();
        feed(8448, -1, 1'b0);
        wait_release(n);
        checks++;
        if (n != 1026 || load_ok !== 1'b1 || load_err !== 1'b0 ||
            byte_count !== 16'd8448) begin
            errors++;
            $display("FAIL reload got n=%0d ok=%b err=%b cnt=%0d exp 1026 1 0 8448",
                     n, load_ok, load_err, byte_count);
        end
    endtask

    initial begin
        reset            = 1'b1;
        dl_bus.dl_active = 1'b0;
        dl_bus.dl_wr     = 1'b0;
        dl_bus.dl_addr   = '0;
        dl_bus.dl_data   = '0;
        step();
        test_reset();
        test_full_load();
        test_rerun();
        test_short();
        test_bad_addr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_dl_ctrl.md
# rom_dl_ctrl

ROM download controller between the HPS download channel (`ioctl_*`) and the Asteroids core ROM write ports. It decodes the flat download stream into three regions: program ROM, vector ROM and state PROM. It issues registered, region-relative write strobes and verifies the byte count. It also owns the core reset: reset is held through every download and for a fixed settle period afterwards, and is released only after a verified load. It sits in `clk_25`, the same clock as `hps_io`, and replaces the raw `ioctl_download` term in the core reset expression.

## Interface
Parameters:
- `PROG_SIZE`, 6144: program ROM bytes, download offsets 0..6143.
- `VEC_SIZE`, 2048: vector ROM bytes, offsets 6144..8191.
- `PROM_SIZE`, 256: state PROM bytes, offsets 8192..8447.
- `HOLD_CYCLES`, 1024: core reset hold after a good load, 1..65535.

Ports:
- `clk_25`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `dl_active`  in  1: download in progress (`ioctl_download`).
- `dl_wr`  in  1: one-cycle byte strobe (`ioctl_wr`).
- `dl_addr`  in  16: byte offset (`ioctl_addr[15:0]`).
- `dl_data`  in  8: byte value.
- `prog_we`  out  1: program ROM write strobe.
- `vec_we`  out  1: vector ROM write strobe.
- `prom_we`  out  1: state PROM write strobe.
- `wr_addr`  out  13: region-relative address.
- `wr_data`  out  8: registered byte.
- `core_reset`  out  1: active-high reset to `ASTEROIDS_TOP` (inverted there to `RESET_L`).
- `load_ok`  out  1: last load verified and core running.
- `load_err`  out  1: last load failed (sticky until the next download starts).
- `byte_count`  out  16: bytes accepted in the current or last load.

## Operation
- States: IDLE, LOAD, CHECK, HOLD, RUN, FAIL.
- IDLE
  - Entered on reset.
  - `core_reset`=1.
  - `dl_active`=1 → LOAD.
- LOAD
  - Entry: clear `byte_count` and `load_err`.
  - Each `dl_wr` with `dl_addr` < TOTAL (= PROG_SIZE+VEC_SIZE+PROM_SIZE):
    - exactly one of the `*_we` strobes pulses;
    - `wr_addr` = `dl_addr` minus the region base;
    - `byte_count` increments.
  - `dl_addr` ≥ TOTAL: no strobe, no count, internal error flag set.
  - `dl_addr` not equal to the previous accepted address + 1, first write excepted: error flag set, write still performed.
  - `dl_active` falls → CHECK.
- CHECK (1 cycle)
  - `byte_count`==TOTAL and no error → HOLD.
  - Otherwise → FAIL, with `load_err`=1.
- HOLD
  - `core_reset`=1 while a 16-bit counter runs 0..HOLD_CYCLES-1.
  - On reaching HOLD_CYCLES-1 → RUN.
- RUN
  - `core_reset`=0, `load_ok`=1.
  - `dl_active`=1 → LOAD; `load_ok` clears and `core_reset` asserts.
- FAIL
  - `core_reset`=1, `load_err`=1.
  - `dl_active`=1 → LOAD.
- `dl_wr` outside LOAD is ignored. No strobes are produced in any other state.
- `byte_count` saturates at 0xFFFF.

## Timing
- Reset values (the first cycle after reset is sampled high):
  - `core_reset`=1;
  - `load_ok`=0, `load_err`=0;
  - all `*_we`=0;
  - `wr_addr`=0, `wr_data`=0;
  - `byte_count`=0.
- Write latency: `dl_wr` at cycle N → `*_we`, `wr_addr` and `wr_data` valid for exactly cycle N+1.
  - `wr_addr` and `wr_data` hold between strobes.
  - Back-to-back `dl_wr` on consecutive cycles is supported at full rate.
- `dl_active` rising at cycle N (from RUN/FAIL/IDLE): `core_reset`=1 and `load_ok`=0 at cycle N+1.
- `dl_wr` in the same cycle that `dl_active` falls: write still accepted and counted. CHECK evaluates at N+1 using the updated count.
- Release: `core_reset` deasserts HOLD_CYCLES+2 cycles after the `dl_active` fall. `load_ok` rises in the same cycle.
- `dl_active` re-asserting during HOLD: → LOAD immediately. `core_reset` stays 1.
- `reset` mid-LOAD: next cycle is IDLE with reset values. A partial load is never reported as ok.
- Region boundaries:
  - offset 6143 → `prog_we`, `wr_addr`=6143;
  - offset 6144 → `vec_we`, `wr_addr`=0;
  - offset 8192 → `prom_we`, `wr_addr`=0.

## Structure
- Shared package `asteroids_pkg` holds:
  - the state enum `dl_state_t`;
  - region base/size localparams, with TOTAL derived from them;
  - the region-select enum {REG_PROG, REG_VEC, REG_PROM, REG_NONE}.
- Natural sub-module: `dl_region_decode`, a combinational decode of address to {region, relative address}, so the boundary logic can be tested on its own.
- Everything else (FSM, counters, output registers) lives in `rom_dl_ctrl`.

## Test plan
- Full sequential load of 8448 bytes, then `dl_active` low:
  - 6144 `prog_we`, 2048 `vec_we`, 256 `prom_we` pulses;
  - `byte_count`=8448;
  - `core_reset` falls exactly HOLD_CYCLES+2 cycles after the fall;
  - `load_ok`=1, `load_err`=0.
- Short load of 8000 bytes: → FAIL; `load_err`=1; `core_reset` stays 1 indefinitely; `load_ok`=0.
- Write at offset 9000 inside an otherwise complete load: no strobe; `byte_count`=8448; `load_err`=1.
- Boundary writes at offsets 6143, 6144, 8191, 8192, 8447: correct strobe, and `wr_addr` = 6143, 0, 2047, 0, 255 respectively; `wr_data` equals the driven byte one cycle later.
- `reset` pulsed at byte 3000, then a full reload: outputs return to reset values the next cycle; the reload ends in RUN with `load_ok`=1.
- Re-download started while in RUN, plus `dl_wr` coincident with the `dl_active` fall: `core_reset`=1 one cycle after the rise; the final byte is counted and the load passes.
